// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/opcode request and result/flag response bundle for alu_seq.
// The master drives the request and out_ready; the slave (the ALU) drives the rest.
interface alu_seq_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   alu_ctrl;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] alu_o;
    logic         cout;
    logic         zero;
    logic         ovf;
    logic         illegal;

    modport master (
        output in_valid, a, b, alu_ctrl, out_ready,
        input  in_ready, out_valid, alu_o, cout, zero, ovf, illegal
    );

    modport slave (
        input  in_valid, a, b, alu_ctrl, out_ready,
        output in_ready, out_valid, alu_o, cout, zero, ovf, illegal
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered W-bit ALU with valid/ready handshakes on both sides.
// Single-cycle ops land in the result register one edge after acceptance;
// the iterative shift-add multiplier (opcode 13) takes W cycles.
// Build option: define ALU_MUL_EN to compile in the multiplier and its MUL
// state; without it opcode 13 is reported as illegal like any unused code.
module alu_seq #(
    parameter int W = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    localparam int SW = $clog2(W);
    localparam int CW = $clog2(W) + 1;

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
`else
    typedef enum logic [0:0] {S_IDLE, S_DONE} state_t;
`endif

    state_t       state_q, state_d;
    logic [W-1:0] alu_q, alu_d;
    logic         cout_q, cout_d;
    logic         zero_q, zero_d;
    logic         ovf_q, ovf_d;
    logic         ill_q, ill_d;
    logic         in_ready_w;
    logic         take_op;

    // Single-cycle datapath results for the opcode currently on the bus
    logic [W:0]    sum_w;
    logic [W:0]    diff_w;
    logic [SW-1:0] sh_w;
    logic [W-1:0]  op_res;
    logic          op_cout;
    logic          op_ovf;
    logic          op_ill;

    assign sum_w  = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff_w = {1'b0, bus.a} - {1'b0, bus.b};
    assign sh_w   = bus.b[SW-1:0];

    // Decode the opcode into result and flags for every single-cycle operation
    always_comb begin
        op_res  = '0;
        op_cout = 1'b0;
        op_ovf  = 1'b0;
        op_ill  = 1'b0;
        case (bus.alu_ctrl)
            4'd0:  op_res = bus.a & bus.b;
            4'd1:  op_res = bus.a | bus.b;
            4'd3:  op_res = bus.a ^ bus.b;
            4'd12: op_res = ~(bus.a | bus.b);
            4'd2: begin
                op_res  = sum_w[W-1:0];
                op_cout = sum_w[W];
                op_ovf  = (bus.a[W-1] == bus.b[W-1]) && (sum_w[W-1] != bus.a[W-1]);
            end
            4'd6: begin
                op_res  = diff_w[W-1:0];
                op_cout = diff_w[W];
                op_ovf  = (bus.a[W-1] != bus.b[W-1]) && (diff_w[W-1] != bus.a[W-1]);
            end
            4'd7:  op_res = {{(W-1){1'b0}}, diff_w[W]};
            4'd8:  op_res = {{(W-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            4'd4:  op_res = bus.a << sh_w;
            4'd5:  op_res = bus.a >> sh_w;
            4'd9:  op_res = W'($signed(bus.a) >>> sh_w);
            default: op_ill = 1'b1;
        endcase
    end

`ifdef ALU_MUL_EN
    // Multiplier: multiplicand shifts left, multiplier shifts right, and the
    // accumulator picks up the multiplicand whenever the multiplier LSB is set.
    logic [2*W-1:0] mcand_q;
    logic [W-1:0]   mplier_q;
    logic [2*W-1:0] acc_q;
    logic [CW-1:0]  count_q;
    logic [2*W-1:0] acc_step;
    logic           start_mul;
    logic           is_mul;

    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign is_mul   = (bus.alu_ctrl == 4'd13);

    // Latch operands on a MUL accept, then step once per cycle in MUL
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else if (start_mul) begin
            mcand_q  <= {{W{1'b0}}, bus.a};
            mplier_q <= bus.b;
            acc_q    <= '0;
            count_q  <= CW'(W);
        end else if (state_q == S_MUL) begin
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q - 1'b1;
        end
    end
`endif

    // Next state, handshake and result-register loads
    always_comb begin
        state_d    = state_q;
        alu_d      = alu_q;
        cout_d     = cout_q;
        zero_d     = zero_q;
        ovf_d      = ovf_q;
        ill_d      = ill_q;
        in_ready_w = 1'b0;
        take_op    = 1'b0;
`ifdef ALU_MUL_EN
        start_mul  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                in_ready_w = 1'b1;
                take_op    = bus.in_valid;
            end
`ifdef ALU_MUL_EN
            S_MUL: begin
                if (count_q == CW'(1)) begin
                    state_d = S_DONE;
                    alu_d   = acc_step[W-1:0];
                    cout_d  = |acc_step[2*W-1:W];
                    zero_d  = (acc_step[W-1:0] == '0);
                    ovf_d   = 1'b0;
                    ill_d   = 1'b0;
                end
            end
`endif
            S_DONE: begin
                // A new op may only enter when the held result leaves
                in_ready_w = bus.out_ready;
                if (bus.out_ready) begin
                    if (bus.in_valid) take_op = 1'b1;
                    else              state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (take_op) begin
`ifdef ALU_MUL_EN
            if (is_mul) begin
                state_d   = S_MUL;
                start_mul = 1'b1;
            end else begin
`else
            begin
`endif
                state_d = S_DONE;
                alu_d   = op_res;
                cout_d  = op_cout;
                zero_d  = (op_res == '0);
                ovf_d   = op_ovf;
                ill_d   = op_ill;
            end
        end
    end

    // State and result registers; reset discards any multiply in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            alu_q   <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            alu_q   <= alu_d;
            cout_q  <= cout_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            ill_q   <= ill_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.alu_o     = alu_q;
    assign bus.cout      = cout_q;
    assign bus.zero      = zero_q;
    assign bus.ovf       = ovf_q;
    assign bus.illegal   = ill_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed literal cases plus randomized traffic for alu_seq,
// checked every cycle against an arithmetic reference model and a queue.
module tb_alu_seq;
    localparam int W    = 8;
    localparam int MAXS = (1 << (W - 1)) - 1;
    localparam int MINS = -(1 << (W - 1));

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   txn      = 0;
    logic rnd_on;

    alu_seq_if #(.W(W)) bus ();

    alu_seq #(.W(W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         z;
        logic         o;
        logic         ill;
        int           due;
    } exp_t;

    exp_t q[$];

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Reference: what the operation must produce, straight from its arithmetic meaning
    function automatic exp_t model(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic [3:0] op);
        exp_t e;
        int sa, sb, sr, sh;
        longint unsigned p;
        sa = $signed(aa);
        sb = $signed(bb);
        sh = int'(bb) % W;
        e.r = '0; e.c = 1'b0; e.o = 1'b0; e.ill = 1'b0; e.due = 0;
        case (op)
            4'd0:  e.r = aa & bb;
            4'd1:  e.r = aa | bb;
            4'd3:  e.r = aa ^ bb;
            4'd12: e.r = ~(aa | bb);
            4'd2: begin
                p   = longint'(aa) + longint'(bb);
                e.r = W'(p);
                e.c = (p >> W) != 0;
                sr  = sa + sb;
                e.o = (sr > MAXS) || (sr < MINS);
            end
            4'd6: begin
                e.r = aa - bb;
                e.c = aa < bb;
                sr  = sa - sb;
                e.o = (sr > MAXS) || (sr < MINS);
            end
            4'd7:  e.r = (aa < bb) ? W'(1) : W'(0);
            4'd8:  e.r = (sa < sb) ? W'(1) : W'(0);
            4'd4:  e.r = aa << sh;
            4'd5:  e.r = aa >> sh;
            4'd9:  e.r = W'(sa >>> sh);
`ifdef ALU_MUL_EN
            4'd13: begin
                p     = longint'(aa) * longint'(bb);
                e.r   = W'(p);
                e.c   = (p >> W) != 0;
                e.due = W;
            end
`endif
            default: e.ill = 1'b1;
        endcase
        e.z = (e.r == '0);
        return e;
    endfunction

    // Per-cycle comparison against the model queue (at most one op in flight)
    always @(negedge clk) begin
        logic ev;
        exp_t e;
        if (!rst_n) begin
            q.delete();
        end else begin
            ev = (q.size() > 0) && (cyc >= q[0].due);
            chk("out_valid", {63'd0, bus.out_valid}, {63'd0, ev});
            chk("in_ready", {63'd0, bus.in_ready},
                {63'd0, (q.size() == 0) || (ev && bus.out_ready)});
            if (ev) begin
                chk("model result", {bus.alu_o, bus.cout, bus.zero, bus.ovf, bus.illegal},
                    {q[0].r, q[0].c, q[0].z, q[0].o, q[0].ill});
                if (bus.out_ready) begin
                    txn++;
                    $display("txn %0d: alu_o=%0h cout=%0b zero=%0b ovf=%0b illegal=%0b",
                             txn, bus.alu_o, bus.cout, bus.zero, bus.ovf, bus.illegal);
                    void'(q.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                e     = model(bus.a, bus.b, bus.alu_ctrl);
                e.due = cyc + 1 + e.due;
                q.push_back(e);
            end
        end
    end

    // Present an op and hold it until the handshake completes; returns at posedge+1
    task automatic send(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic [3:0] op);
        logic acc;
        int n;
        acc = 1'b0;
        n   = 0;
        bus.in_valid = 1'b1;
        bus.a        = aa;
        bus.b        = bb;
        bus.alu_ctrl = op;
        while (!acc && n < 1000) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        chk("send accept", {63'd0, acc}, 64'd1);
    endtask

    // Wait for the result, check latency and literal values, let it be taken
    task automatic expect_out(input string nm, input logic [W-1:0] r, input logic c, input logic z,
                              input logic o, input logic ill, input int k_exp);
        int k;
        k = 0;
        @(negedge clk);
        while (!bus.out_valid && k < 200) begin
            k++;
            @(negedge clk);
        end
        chk({nm, " latency"}, 64'(k), 64'(k_exp));
        chk({nm, " result"}, {bus.alu_o, bus.cout, bus.zero, bus.ovf, bus.illegal}, {r, c, z, o, ill});
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return W'(1) << (W - 1);
            3: return ~(W'(1) << (W - 1));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        rnd_on       = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.alu_ctrl = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("reset result", {bus.alu_o, bus.cout, bus.zero, bus.ovf, bus.illegal}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("reset in_ready", {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk);
        #1;

        send(8'd200, 8'd100, 4'd2);  expect_out("add carry", 8'd44, 1, 0, 0, 0, 0);
        send(8'd100, 8'd100, 4'd2);  expect_out("add ovf", 8'd200, 0, 0, 1, 0, 0);
        send(8'd5, 8'd7, 4'd6);      expect_out("sub borrow", 8'd254, 1, 0, 0, 0, 0);
        send(8'd9, 8'd9, 4'd6);      expect_out("sub zero", 8'd0, 0, 1, 0, 0, 0);
        send(8'hFF, 8'h01, 4'd8);    expect_out("slts", 8'd1, 0, 0, 0, 0, 0);
        send(8'hFF, 8'h01, 4'd7);    expect_out("slt", 8'd0, 0, 1, 0, 0, 0);
        send(8'h80, 8'd3, 4'd9);     expect_out("sra", 8'hF0, 0, 0, 0, 0, 0);
        send(8'h80, 8'd3, 4'd5);     expect_out("srl", 8'h10, 0, 0, 0, 0, 0);
        send(8'h81, 8'd9, 4'd4);     expect_out("sll mod", 8'h02, 0, 0, 0, 0, 0);

        // Back-pressure: three ops queued behind a stalled consumer
        bus.out_ready = 1'b0;
        send(8'h0F, 8'h3C, 4'd0);
        fork
            begin
                send(8'h0F, 8'h3C, 4'd1);
                send(8'h0F, 8'h3C, 4'd12);
            end
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("bp in_ready", {63'd0, bus.in_ready}, 64'd0);
                    chk("bp hold", {bus.out_valid, bus.alu_o}, {1'b1, 8'h0C});
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
                @(negedge clk); chk("bp and", {bus.out_valid, bus.alu_o}, {1'b1, 8'h0C});
                @(negedge clk); chk("bp or",  {bus.out_valid, bus.alu_o}, {1'b1, 8'h3F});
                @(negedge clk); chk("bp nor", {bus.out_valid, bus.alu_o}, {1'b1, 8'hC0});
            end
        join
        @(posedge clk);
        #1;

`ifdef ALU_MUL_EN
        send(8'd13, 8'd11, 4'd13);   expect_out("mul small", 8'd143, 0, 0, 0, 0, W);
        send(8'd20, 8'd20, 4'd13);   expect_out("mul high", 8'd144, 1, 0, 0, 0, W);
`else
        send(8'd13, 8'd11, 4'd13);   expect_out("mul off", 8'd0, 0, 1, 0, 1, 0);
        send(8'd20, 8'd20, 4'd2);    expect_out("add pre-reset", 8'd40, 0, 0, 0, 0, 0);
`endif

        // Reset in the 4th cycle after a multiply is accepted
        send(8'd5, 8'd6, 4'd13);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("mid reset out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("mid reset result", {bus.alu_o, bus.cout, bus.zero, bus.ovf, bus.illegal}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post reset in_ready", {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk);
        #1;
        send(8'd1, 8'd1, 4'd2);      expect_out("add after reset", 8'd2, 0, 0, 0, 0, 0);
        send(8'h12, 8'h34, 4'd15);   expect_out("illegal 15", 8'd0, 0, 1, 0, 1, 0);

        // Randomized traffic with random consumer stalls
        rnd_on = 1'b1;
        fork
            begin
                while (rnd_on) begin
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 300; i++) begin
                    send(pick_operand(), pick_operand(), 4'($urandom_range(0, 15)));
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rnd_on = 1'b0;
            end
        join
        repeat (W + 6) @(posedge clk);
        #1;
        chk("drained", 64'(q.size()), 64'd0);
        chk("final out_valid", {63'd0, bus.out_valid}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
